// File: rtl/mod12_seq_ctrl_pkg.sv
// Shared types and mod-12 arithmetic for the counter sequencing controller.
package mod12_seq_ctrl_pkg;

  localparam int unsigned MOD12 = 12;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_UP    = 2'd1,
    OP_DOWN  = 2'd2,
    OP_CLEAR = 2'd3
  } ctl_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } seq_state_e;

  function automatic logic [CNT_W-1:0] next_mod(input logic [CNT_W-1:0] count, input logic up);
    if (up) begin
      return (count == CNT_W'(MOD12 - 1)) ? '0 : count + CNT_W'(1);
    end else begin
      return (count == '0) ? CNT_W'(MOD12 - 1) : count - CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/mod12_seq_ctrl_arb.sv
// Two-way round-robin arbiter; on advance, priority moves to the requester
// that did not own the most recent grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  logic ptr_q;
  logic owner_q;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      if (|grant) begin
        owner_q <= grant[1];
      end
      if (advance) begin
        ptr_q <= ~owner_q;
      end
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mod12_seq_ctrl.sv
// Sequences LOAD/UP/DOWN/CLEAR commands from two requesters onto a mod-12
// up/down counter, holding it static between commands.
module mod12_seq_ctrl
  import mod12_seq_ctrl_pkg::*;
#(
  parameter int unsigned MODULUS = 12,
  parameter int unsigned CW      = 4,
  parameter int unsigned STEP_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0][1:0]     req_op,
  input  logic [1:0][CW-1:0]  req_val,
  output logic                resp_valid,
  output logic                resp_id,
  output logic [CW-1:0]       resp_count,
  output logic                resp_err,
  output logic                ctr_load,
  output logic                ctr_up_down,
  output logic [CW-1:0]       ctr_din,
  output logic                ctr_rst,
  input  logic [CW-1:0]       ctr_count
);

  seq_state_e        state_q, state_d;
  ctl_op_e           op_q;
  logic [CW-1:0]     val_q;
  logic [CW-1:0]     shadow_q, shadow_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              id_q;
  logic              err_q, err_d;

  logic [1:0] arb_req;
  logic [1:0] grant;
  logic       ptr;
  logic       accept;
  logic       sel_id;
  logic       clear_pulse;
  logic       advance;

  // Requests are only visible to the arbiter while idle, so a grant is a transfer.
  assign arb_req = (state_q == S_IDLE) ? req_valid : 2'b00;
  assign accept  = |grant;
  assign sel_id  = (&arb_req) ? ptr : arb_req[1];

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (advance),
    .grant   (grant),
    .ptr     (ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      op_q     <= OP_LOAD;
      val_q    <= '0;
      rem_q    <= '0;
      id_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      if (accept) begin
        op_q  <= ctl_op_e'(req_op[sel_id]);
        val_q <= req_val[sel_id];
        id_q  <= sel_id;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    rem_d       = rem_q;
    err_d       = err_q;
    req_ready   = 2'b00;
    ctr_load    = 1'b1;
    ctr_din     = shadow_q;
    ctr_up_down = 1'b0;
    clear_pulse = 1'b0;
    resp_valid  = 1'b0;
    resp_id     = 1'b0;
    resp_count  = '0;
    resp_err    = 1'b0;
    advance     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = grant;
        if (accept) begin
          rem_d   = STEP_W'(req_val[sel_id]);
          err_d   = 1'b0;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        unique case (op_q)
          OP_LOAD: begin
            if (val_q <= CW'(MODULUS - 1)) begin
              ctr_din  = val_q;
              shadow_d = val_q;
            end else begin
              err_d = 1'b1;
            end
            state_d = S_RESP;
          end
          OP_UP, OP_DOWN: begin
            if (rem_q == '0) begin
              state_d = S_RESP;
            end else begin
              ctr_load    = 1'b0;
              ctr_up_down = (op_q == OP_UP);
              shadow_d    = CW'(next_mod(CNT_W'(shadow_q), op_q == OP_UP));
              rem_d       = rem_q - STEP_W'(1);
              if (rem_q == STEP_W'(1)) begin
                state_d = S_RESP;
              end
            end
          end
          OP_CLEAR: begin
            clear_pulse = 1'b1;
            shadow_d    = '0;
            state_d     = S_RESP;
          end
          default: state_d = S_RESP;
        endcase
      end

      S_RESP: begin
        resp_valid = 1'b1;
        resp_id    = id_q;
        resp_count = shadow_q;
        // Also flags a counter that drifted from the shadow copy.
        resp_err   = err_q | (ctr_count != shadow_q);
        advance    = 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign ctr_rst = rst | clear_pulse;

endmodule

// File: tb/tb_mod12_seq_ctrl.sv
// Directed bench: drives mod12_seq_ctrl against a behavioural mod-12 counter.
module tb_mod12_seq_ctrl;
  import mod12_seq_ctrl_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][1:0] req_op;
  logic [1:0][3:0] req_val;
  logic            resp_valid;
  logic            resp_id;
  logic [3:0]      resp_count;
  logic            resp_err;
  logic            ctr_load;
  logic            ctr_up_down;
  logic [3:0]      ctr_din;
  logic            ctr_rst;
  logic [3:0]      ctr_count;

  logic [3:0] cnt_q;
  logic       force_en;
  logic [3:0] force_val;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mod12_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_val     (req_val),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_count  (resp_count),
    .resp_err    (resp_err),
    .ctr_load    (ctr_load),
    .ctr_up_down (ctr_up_down),
    .ctr_din     (ctr_din),
    .ctr_rst     (ctr_rst),
    .ctr_count   (ctr_count)
  );

  // Reference mod-12 counter: rst beats load, load beats count.
  always_ff @(posedge clk) begin
    if (ctr_rst) cnt_q <= 4'd0;
    else if (ctr_load) cnt_q <= ctr_din;
    else if (ctr_up_down) cnt_q <= (cnt_q == 4'd11) ? 4'd0 : cnt_q + 4'd1;
    else cnt_q <= (cnt_q == 4'd0) ? 4'd11 : cnt_q - 4'd1;
  end

  assign ctr_count = force_en ? force_val : cnt_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command at the current negedge, wait for its response, check it.
  task automatic do_cmd(input int id, input logic [1:0] op, input logic [3:0] val,
                        input int lat, input logic [3:0] ecnt, input logic eerr);
    int n;
    req_valid[id] = 1'b1;
    req_op[id]    = op;
    req_val[id]   = val;
    #1;
    chk("cmd_ready", {30'd0, req_ready}, (id == 0) ? 32'd1 : 32'd2);
    @(negedge clk);
    req_valid = 2'b00;
    n = 1;
    while (!resp_valid && n < lat + 4) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_latency", n, lat);
    chk("cmd_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("cmd_resp_id", {31'd0, resp_id}, id);
    chk("cmd_resp_count", {28'd0, resp_count}, {28'd0, ecnt});
    chk("cmd_resp_err", {31'd0, resp_err}, {31'd0, eerr});
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int gi;
    int ri;
    rst = 1'b1;
    req_valid = 2'b00;
    req_op = '0;
    req_val = '0;
    force_en = 1'b0;
    force_val = 4'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctr_rst", {31'd0, ctr_rst}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_resp_count", {28'd0, resp_count}, 32'd0);
    chk("rst_resp_id_err", {30'd0, resp_id, resp_err}, 32'd0);
    chk("rst_cnt", {28'd0, cnt_q}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_hold_load", {31'd0, ctr_load}, 32'd1);
    chk("idle_hold_din", {28'd0, ctr_din}, 32'd0);
    chk("idle_ctr_rst", {31'd0, ctr_rst}, 32'd0);

    // LOAD 7 from requester 0, cycle by cycle
    req_valid[0] = 1'b1;
    req_op[0] = OP_LOAD;
    req_val[0] = 4'd7;
    #1;
    chk("load7_ready", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    chk("load7_ctr_load", {31'd0, ctr_load}, 32'd1);
    chk("load7_ctr_din", {28'd0, ctr_din}, 32'd7);
    chk("load7_ready_exec", {30'd0, req_ready}, 32'd0);
    chk("load7_no_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("load7_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("load7_resp_id", {31'd0, resp_id}, 32'd0);
    chk("load7_resp_count", {28'd0, resp_count}, 32'd7);
    chk("load7_resp_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    chk("load7_cnt", {28'd0, cnt_q}, 32'd7);
    chk("load7_resp_pulse", {31'd0, resp_valid}, 32'd0);

    // From 10, UP 3 wraps through 11, 0, 1
    do_cmd(0, OP_LOAD, 4'd10, 2, 4'd10, 1'b0);
    req_valid[0] = 1'b1;
    req_op[0] = OP_UP;
    req_val[0] = 4'd3;
    #1;
    chk("up3_ready", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    chk("up3_load0_a", {31'd0, ctr_load}, 32'd0);
    chk("up3_dir", {31'd0, ctr_up_down}, 32'd1);
    @(negedge clk);
    chk("up3_cnt_11", {28'd0, cnt_q}, 32'd11);
    chk("up3_load0_b", {31'd0, ctr_load}, 32'd0);
    @(negedge clk);
    chk("up3_cnt_0", {28'd0, cnt_q}, 32'd0);
    chk("up3_load0_c", {31'd0, ctr_load}, 32'd0);
    @(negedge clk);
    chk("up3_cnt_1", {28'd0, cnt_q}, 32'd1);
    chk("up3_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("up3_resp_count", {28'd0, resp_count}, 32'd1);
    chk("up3_resp_err", {31'd0, resp_err}, 32'd0);
    chk("up3_hold", {31'd0, ctr_load}, 32'd1);
    @(negedge clk);

    // From 1, DOWN 15 by requester 1 lands on 10 and stays there
    do_cmd(1, OP_DOWN, 4'd15, 16, 4'd10, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("down15_hold_cnt", {28'd0, cnt_q}, 32'd10);
      @(negedge clk);
    end

    // Both requesters valid continuously: grants alternate starting at r0
    req_valid = 2'b11;
    req_op[0] = OP_LOAD;
    req_op[1] = OP_LOAD;
    req_val[0] = 4'd3;
    req_val[1] = 4'd5;
    gi = 0;
    ri = 0;
    for (int c = 0; c < 60 && ri < 4; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        chk("rr_grant", {30'd0, req_ready}, (gi % 2 == 0) ? 32'd1 : 32'd2);
        gi++;
      end
      if (resp_valid) begin
        chk("rr_resp_id", {31'd0, resp_id}, ri % 2);
        chk("rr_resp_count", {28'd0, resp_count}, (ri % 2 == 0) ? 32'd3 : 32'd5);
        ri++;
      end
      if (ri < 4) @(negedge clk);
    end
    req_valid = 2'b00;
    chk("rr_grants_seen", gi, 4);
    chk("rr_resps_seen", ri, 4);
    @(negedge clk);

    // Illegal LOAD 13 keeps count at 5 and flags an error
    do_cmd(0, OP_LOAD, 4'd13, 2, 4'd5, 1'b1);
    chk("load13_cnt", {28'd0, cnt_q}, 32'd5);

    // CLEAR pulses the counter reset
    req_valid[0] = 1'b1;
    req_op[0] = OP_CLEAR;
    #1;
    chk("clear_ready", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    chk("clear_ctr_rst", {31'd0, ctr_rst}, 32'd1);
    @(negedge clk);
    chk("clear_ctr_rst_done", {31'd0, ctr_rst}, 32'd0);
    chk("clear_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("clear_resp_count", {28'd0, resp_count}, 32'd0);
    chk("clear_resp_err", {31'd0, resp_err}, 32'd0);
    chk("clear_cnt", {28'd0, cnt_q}, 32'd0);
    @(negedge clk);

    // LOAD 4, then pull ctr_count away from the shadow during RESP
    req_valid[0] = 1'b1;
    req_op[0] = OP_LOAD;
    req_val[0] = 4'd4;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    force_en = 1'b1;
    force_val = 4'd9;
    #1;
    chk("mismatch_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("mismatch_resp_count", {28'd0, resp_count}, 32'd4);
    chk("mismatch_resp_err", {31'd0, resp_err}, 32'd1);
    force_en = 1'b0;
    @(negedge clk);

    // Reset in the middle of UP 8 aborts without a response
    req_valid[0] = 1'b1;
    req_op[0] = OP_UP;
    req_val[0] = 4'd8;
    #1;
    chk("up8_ready", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("up8_stepping", {28'd0, cnt_q}, 32'd6);
    rst = 1'b1;
    #1;
    chk("abort_ctr_rst", {31'd0, ctr_rst}, 32'd1);
    chk("abort_no_resp_a", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_cnt", {28'd0, cnt_q}, 32'd0);
    chk("abort_idle_load", {31'd0, ctr_load}, 32'd1);
    chk("abort_idle_din", {28'd0, ctr_din}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    @(negedge clk);
    do_cmd(0, OP_UP, 4'd2, 3, 4'd2, 1'b0);
    chk("up2_cnt", {28'd0, cnt_q}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
